// File: rtl/gate_result_checker_if.sv
// Bus between a gate-block stimulus/response source and the gate result checker.
// master drives the run control, stimulus and gate outputs; slave reports the verdict.
interface gate_result_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             stop;
  logic [1:0]       entrada;
  logic             entrada_valid;
  logic [5:0]       salidas;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       first_err_vec;
  logic [5:0]       first_err_mask;
  logic             err_flag;

  modport master (
    output start, stop, entrada, entrada_valid, salidas,
    input  busy, done, pass, vec_count, err_count,
           first_err_vec, first_err_mask, err_flag
  );

  modport slave (
    input  start, stop, entrada, entrada_valid, salidas,
    output busy, done, pass, vec_count, err_count,
           first_err_vec, first_err_mask, err_flag
  );
endinterface

// File: rtl/gate_result_checker.sv
// Checks the six gate outputs against a golden truth table after a settle delay,
// accumulating saturating vector/error counts and the first failing vector.
module gate_result_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input logic                  clk,
  input logic                  rst,
  gate_result_checker_if.slave bus
);

  localparam int unsigned SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {IDLE, RUN, SETTLE, CHECK, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [1:0]       vec_reg;
  logic [SW-1:0]    settle_cnt;
  logic             stop_pend;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] vec_count_q;
  logic [CNT_W-1:0] err_count_q;
  logic [1:0]       first_err_vec_q;
  logic [5:0]       first_err_mask_q;
  logic             err_flag_q;
  logic [5:0]       mask_c;

  // Output order {XNOR, XOR, NOR, AND, OR, NOT_A} with A = v[1], B = v[0].
  function automatic logic [5:0] golden(input logic [1:0] v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    return {~(a ^ b), a ^ b, ~(a | b), a & b, a | b, ~a};
  endfunction

  assign mask_c = bus.salidas ^ golden(vec_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN: begin
        if (bus.entrada_valid) next_state = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
        else if (bus.stop)     next_state = DONE;
      end
      // A fresh strobe restarts the settle window instead of completing it.
      SETTLE:  if (!bus.entrada_valid && settle_cnt <= SW'(1)) next_state = CHECK;
      CHECK:   next_state = (stop_pend || bus.stop) ? DONE : RUN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_reg          <= 2'b00;
      settle_cnt       <= '0;
      stop_pend        <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      vec_count_q      <= '0;
      err_count_q      <= '0;
      first_err_vec_q  <= 2'b00;
      first_err_mask_q <= 6'b0;
      err_flag_q       <= 1'b0;
    end else begin
      busy_q <= (next_state != IDLE);
      done_q <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            stop_pend        <= 1'b0;
            pass_q           <= 1'b0;
            vec_count_q      <= '0;
            err_count_q      <= '0;
            first_err_vec_q  <= 2'b00;
            first_err_mask_q <= 6'b0;
            err_flag_q       <= 1'b0;
          end
        end
        RUN: begin
          if (bus.entrada_valid) begin
            vec_reg    <= bus.entrada;
            settle_cnt <= SW'(SETTLE_CYCLES);
            stop_pend  <= bus.stop;
          end
        end
        SETTLE: begin
          if (bus.entrada_valid) begin
            vec_reg    <= bus.entrada;
            settle_cnt <= SW'(SETTLE_CYCLES);
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
          if (bus.stop) stop_pend <= 1'b1;
        end
        CHECK: begin
          if (vec_count_q != CNT_MAX) vec_count_q <= vec_count_q + CNT_W'(1);
          if (mask_c != 6'b0) begin
            if (err_count_q != CNT_MAX) err_count_q <= err_count_q + CNT_W'(1);
            err_flag_q <= 1'b1;
            // err_flag still low means this is the first mismatch of the run.
            if (!err_flag_q) begin
              first_err_vec_q  <= vec_reg;
              first_err_mask_q <= mask_c;
            end
          end
        end
        DONE: begin
          pass_q    <= (err_count_q == '0);
          stop_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.vec_count      = vec_count_q;
  assign bus.err_count      = err_count_q;
  assign bus.first_err_vec  = first_err_vec_q;
  assign bus.first_err_mask = first_err_mask_q;
  assign bus.err_flag       = err_flag_q;

endmodule

// File: tb/tb_gate_result_checker.sv
// Scoreboard bench: run results are queued when stop is issued and compared
// by a per-DUT monitor whenever that DUT pulses done.
module tb_gate_result_checker;

  typedef struct packed {
    logic [7:0] vec;
    logic [7:0] err;
    logic       pass;
    logic       flag;
    logic [1:0] fev;
    logic [5:0] fem;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] force_zero;
  logic [5:0] flip;
  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  gate_result_checker_if #(.CNT_W(8)) ia ();
  gate_result_checker_if #(.CNT_W(2)) ib ();

  gate_result_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) dut     (.clk(clk), .rst(rst), .bus(ia));
  gate_result_checker #(.SETTLE_CYCLES(0), .CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(ib));

  // Hand-written truth table of the gate block, {XNOR, XOR, NOR, AND, OR, NOT_A}.
  function automatic logic [5:0] gold_tbl(input logic [1:0] v);
    case (v)
      2'b00:   return 6'b101001;
      2'b01:   return 6'b010011;
      2'b10:   return 6'b010010;
      default: return 6'b100110;
    endcase
  endfunction

  assign ia.salidas = (gold_tbl(ia.entrada) & ~force_zero) ^ flip;
  assign ib.salidas = (gold_tbl(ib.entrada) & ~force_zero) ^ flip;

  function automatic exp_t mk(input logic [7:0] vec, input logic [7:0] err, input logic pass,
                              input logic flag, input logic [1:0] fev, input logic [5:0] fem);
    exp_t e;
    e.vec = vec; e.err = err; e.pass = pass; e.flag = flag; e.fev = fev; e.fem = fem;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the main instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ia.done === 1'b1) begin
        chk("a_done_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("a_busy_at_done", 32'(ia.busy), 32'd1);
          chk("a_vec_count", 32'(ia.vec_count), 32'(e.vec));
          chk("a_err_count", 32'(ia.err_count), 32'(e.err));
          chk("a_err_flag", 32'(ia.err_flag), 32'(e.flag));
          chk("a_first_err_vec", 32'(ia.first_err_vec), 32'(e.fev));
          chk("a_first_err_mask", 32'(ia.first_err_mask), 32'(e.fem));
          @(negedge clk);
          chk("a_done_single", 32'(ia.done), 32'd0);
          chk("a_pass", 32'(ia.pass), 32'(e.pass));
        end
      end
    end
  end

  // Monitor for the saturating zero-settle instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ib.done === 1'b1) begin
        chk("b_done_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("b_vec_count", 32'(ib.vec_count), 32'(e.vec));
          chk("b_err_count", 32'(ib.err_count), 32'(e.err));
          chk("b_err_flag", 32'(ib.err_flag), 32'(e.flag));
          chk("b_first_err_vec", 32'(ib.first_err_vec), 32'(e.fev));
          chk("b_first_err_mask", 32'(ib.first_err_mask), 32'(e.fem));
          @(negedge clk);
          chk("b_done_single", 32'(ib.done), 32'd0);
          chk("b_pass", 32'(ib.pass), 32'(e.pass));
        end
      end
    end
  end

  task automatic a_vec(input logic [1:0] v);
    ia.entrada = v; ia.entrada_valid = 1'b1; tick(); ia.entrada_valid = 1'b0;
  endtask
  task automatic b_vec(input logic [1:0] v);
    ib.entrada = v; ib.entrada_valid = 1'b1; tick(); ib.entrada_valid = 1'b0;
  endtask
  task automatic a_start(); ia.start = 1'b1; tick(); ia.start = 1'b0; endtask
  task automatic b_start(); ib.start = 1'b1; tick(); ib.start = 1'b0; endtask
  task automatic a_stop();  ia.stop  = 1'b1; tick(); ia.stop  = 1'b0; endtask
  task automatic b_stop();  ib.stop  = 1'b1; tick(); ib.stop  = 1'b0; endtask

  task automatic wait_idle(input bit which_b, input string name);
    for (int i = 0; i < 20; i++) begin
      if (!(which_b ? ib.busy : ia.busy)) break;
      tick();
    end
    chk(name, 32'(which_b ? ib.busy : ia.busy), 32'd0);
    repeat (2) tick();
  endtask

  task automatic check_a_zero(input string tag);
    chk({tag, "_busy"}, 32'(ia.busy), 32'd0);
    chk({tag, "_done"}, 32'(ia.done), 32'd0);
    chk({tag, "_pass"}, 32'(ia.pass), 32'd0);
    chk({tag, "_vec"}, 32'(ia.vec_count), 32'd0);
    chk({tag, "_err"}, 32'(ia.err_count), 32'd0);
    chk({tag, "_fev"}, 32'(ia.first_err_vec), 32'd0);
    chk({tag, "_fem"}, 32'(ia.first_err_mask), 32'd0);
    chk({tag, "_flag"}, 32'(ia.err_flag), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    force_zero = 6'b0;
    flip = 6'b0;
    ia.start = 1'b0; ia.stop = 1'b0; ia.entrada = 2'b00; ia.entrada_valid = 1'b0;
    ib.start = 1'b0; ib.stop = 1'b0; ib.entrada = 2'b00; ib.entrada_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_a_zero("reset");
    chk("reset_b_busy", 32'(ib.busy), 32'd0);

    // Strobes without start are ignored.
    for (int i = 0; i < 3; i++) begin
      a_vec(2'(i + 1));
      tick();
    end
    repeat (4) tick();
    chk("idle_vec", 32'(ia.vec_count), 32'd0);
    chk("idle_busy", 32'(ia.busy), 32'd0);

    // Correct gate model, all four vectors.
    a_start();
    chk("start_busy", 32'(ia.busy), 32'd1);
    for (int v = 0; v < 4; v++) begin
      a_vec(2'(v));
      repeat (5) tick();
    end
    qa.push_back(mk(8'd4, 8'd0, 1'b1, 1'b0, 2'b00, 6'b000000));
    a_stop();
    wait_idle(1'b0, "run_good_end");

    // XOR stuck at 0: vectors 01 and 10 fail.
    force_zero = 6'b010000;
    a_start();
    for (int v = 0; v < 4; v++) begin
      a_vec(2'(v));
      repeat (5) tick();
    end
    qa.push_back(mk(8'd4, 8'd2, 1'b0, 1'b1, 2'b01, 6'b010000));
    a_stop();
    wait_idle(1'b0, "run_xor_end");

    // Superseded strobe: 01 would fail, only 11 (passing) may be checked.
    a_start();
    a_vec(2'b01);
    a_vec(2'b11);
    repeat (6) tick();
    qa.push_back(mk(8'd1, 8'd0, 1'b1, 1'b0, 2'b00, 6'b000000));
    a_stop();
    wait_idle(1'b0, "run_supersede_end");

    // stop together with a strobe: vector still checked.
    a_start();
    qa.push_back(mk(8'd1, 8'd1, 1'b0, 1'b1, 2'b10, 6'b010000));
    ia.entrada = 2'b10; ia.entrada_valid = 1'b1; ia.stop = 1'b1;
    tick();
    ia.entrada_valid = 1'b0; ia.stop = 1'b0;
    wait_idle(1'b0, "run_stopvalid_end");

    // Reset mid-run during SETTLE after one error was counted.
    a_start();
    a_vec(2'b01);
    repeat (5) tick();
    chk("pre_rst_err", 32'(ia.err_count), 32'd1);
    a_vec(2'b11);
    rst = 1'b1;
    #1;
    check_a_zero("abort");
    tick();
    rst = 1'b0;
    repeat (3) tick();
    force_zero = 6'b0;
    a_start();
    a_vec(2'b11);
    repeat (5) tick();
    qa.push_back(mk(8'd1, 8'd0, 1'b1, 1'b0, 2'b00, 6'b000000));
    a_stop();
    wait_idle(1'b0, "run_after_rst_end");

    // Saturation with 2-bit counters and zero settle delay.
    flip = 6'b000001;
    b_start();
    for (int i = 0; i < 5; i++) begin
      b_vec(2'(i));
      repeat (3) tick();
    end
    qb.push_back(mk(8'd3, 8'd3, 1'b0, 1'b1, 2'b00, 6'b000001));
    b_stop();
    wait_idle(1'b1, "run_sat_end");
    flip = 6'b0;

    repeat (5) tick();
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
